// File: rtl/ps2_keyboard_if.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// ps2_keyboard_if - KBD/KBDCR register bus between the 6502 and the keyboard. Rev 1.0
//==============================================================================
interface ps2_keyboard_if;
  logic       enable;
  logic       address;
  logic [7:0] dout;

  modport master (output enable, output address, input dout);
  modport slave  (input enable, input address, output dout);
endinterface
`default_nettype wire

// File: rtl/ps2_keyboard.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// ps2_keyboard - PS/2 Set-2 receiver and Apple-1 ASCII decoder with KBD/KBDCR. Rev 1.0
//==============================================================================
module ps2_keyboard #(
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic          clk25,
  input  logic          rst_n,
  ps2_keyboard_if.slave bus,
  input  logic          ps2_clk,
  input  logic          ps2_din,
  output logic          clr_screen,
  output logic          reset_key
);
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  localparam logic [3:0]  LAST_BIT    = 4'd10;

  logic [1:0]  clk_sync_q, din_sync_q;
  logic        clk_prev_q;
  logic        fall;

  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [10:0] shift_q, shift_d;
  logic [15:0] idle_q, idle_d;
  logic        frame_done_q, frame_done_d;

  logic        break_q, break_d;
  logic        ext_q, ext_d;
  logic        shift_held_q, shift_held_d;
  logic [6:0]  key_q, key_d;
  logic        ready_q, ready_d;
  logic        clr_q, clr_d;
  logic        rstkey_q, rstkey_d;

  logic [7:0]  rx_byte;
  logic        frame_ok;
  logic        is_shift;
  logic [7:0]  key_map;

  // Sync flops idle high so reset release never looks like a falling edge.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      din_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      din_sync_q <= {din_sync_q[0], ps2_din};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q[1];

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    idle_d       = idle_q;
    frame_done_d = 1'b0;
    if (fall) begin
      idle_d  = '0;
      shift_d = {din_sync_q[1], shift_q[10:1]};
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else begin
      if (idle_q != TIMEOUT_LIM) begin
        idle_d = idle_q + 16'd1;
      end
      if ((idle_q == TIMEOUT_LIM) && (bit_cnt_q != 4'd0)) begin
        bit_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      idle_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      idle_q       <= idle_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Frame layout after 11 right-shifts: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  assign rx_byte  = shift_q[8:1];
  assign frame_ok = frame_done_q & ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);
  assign is_shift = (rx_byte == 8'h12) || (rx_byte == 8'h59);

  // Returns {valid, ascii}; letters are always upper case on the Apple-1.
  function automatic logic [7:0] map_code(input logic [7:0] code, input logic sh);
    map_code = 8'h00;
    case (code)
      8'h1C: map_code = {1'b1, 7'h41};
      8'h32: map_code = {1'b1, 7'h42};
      8'h21: map_code = {1'b1, 7'h43};
      8'h23: map_code = {1'b1, 7'h44};
      8'h24: map_code = {1'b1, 7'h45};
      8'h2B: map_code = {1'b1, 7'h46};
      8'h34: map_code = {1'b1, 7'h47};
      8'h33: map_code = {1'b1, 7'h48};
      8'h43: map_code = {1'b1, 7'h49};
      8'h3B: map_code = {1'b1, 7'h4A};
      8'h42: map_code = {1'b1, 7'h4B};
      8'h4B: map_code = {1'b1, 7'h4C};
      8'h3A: map_code = {1'b1, 7'h4D};
      8'h31: map_code = {1'b1, 7'h4E};
      8'h44: map_code = {1'b1, 7'h4F};
      8'h4D: map_code = {1'b1, 7'h50};
      8'h15: map_code = {1'b1, 7'h51};
      8'h2D: map_code = {1'b1, 7'h52};
      8'h1B: map_code = {1'b1, 7'h53};
      8'h2C: map_code = {1'b1, 7'h54};
      8'h3C: map_code = {1'b1, 7'h55};
      8'h2A: map_code = {1'b1, 7'h56};
      8'h1D: map_code = {1'b1, 7'h57};
      8'h22: map_code = {1'b1, 7'h58};
      8'h35: map_code = {1'b1, 7'h59};
      8'h1A: map_code = {1'b1, 7'h5A};
      8'h16: map_code = {1'b1, sh ? 7'h21 : 7'h31};
      8'h1E: map_code = {1'b1, sh ? 7'h40 : 7'h32};
      8'h26: map_code = {1'b1, sh ? 7'h23 : 7'h33};
      8'h25: map_code = {1'b1, sh ? 7'h24 : 7'h34};
      8'h2E: map_code = {1'b1, sh ? 7'h25 : 7'h35};
      8'h36: map_code = {1'b1, sh ? 7'h5E : 7'h36};
      8'h3D: map_code = {1'b1, sh ? 7'h26 : 7'h37};
      8'h3E: map_code = {1'b1, sh ? 7'h2A : 7'h38};
      8'h46: map_code = {1'b1, sh ? 7'h28 : 7'h39};
      8'h45: map_code = {1'b1, sh ? 7'h29 : 7'h30};
      8'h4E: map_code = {1'b1, sh ? 7'h5F : 7'h2D};
      8'h55: map_code = {1'b1, sh ? 7'h2B : 7'h3D};
      8'h54: map_code = {1'b1, sh ? 7'h7B : 7'h5B};
      8'h5B: map_code = {1'b1, sh ? 7'h7D : 7'h5D};
      8'h5D: map_code = {1'b1, sh ? 7'h7C : 7'h5C};
      8'h4C: map_code = {1'b1, sh ? 7'h3A : 7'h3B};
      8'h52: map_code = {1'b1, sh ? 7'h22 : 7'h27};
      8'h41: map_code = {1'b1, sh ? 7'h3C : 7'h2C};
      8'h49: map_code = {1'b1, sh ? 7'h3E : 7'h2E};
      8'h4A: map_code = {1'b1, sh ? 7'h3F : 7'h2F};
      8'h0E: map_code = {1'b1, sh ? 7'h7E : 7'h60};
      8'h29: map_code = {1'b1, 7'h20};
      8'h5A: map_code = {1'b1, 7'h0D};
      8'h76: map_code = {1'b1, 7'h1B};
      8'h66: map_code = {1'b1, 7'h5F};
      default: map_code = 8'h00;
    endcase
  endfunction

  assign key_map = map_code(rx_byte, shift_held_q);

  // A key load later in this block overrides the read-clear of ready.
  always_comb begin
    break_d      = break_q;
    ext_d        = ext_q;
    shift_held_d = shift_held_q;
    key_d        = key_q;
    ready_d      = ready_q;
    clr_d        = 1'b0;
    rstkey_d     = 1'b0;
    if (bus.enable && !bus.address) begin
      ready_d = 1'b0;
    end
    if (frame_ok) begin
      if (rx_byte == 8'hE0) begin
        ext_d = 1'b1;
      end else if (rx_byte == 8'hF0) begin
        break_d = 1'b1;
      end else begin
        break_d = 1'b0;
        ext_d   = 1'b0;
        if (!ext_q) begin
          if (is_shift) begin
            shift_held_d = ~break_q;
          end else if (!break_q) begin
            if (rx_byte == 8'h05) begin
              clr_d = 1'b1;
            end else if (rx_byte == 8'h07) begin
              rstkey_d = 1'b1;
            end else if (key_map[7]) begin
              key_d   = key_map[6:0];
              ready_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      break_q      <= 1'b0;
      ext_q        <= 1'b0;
      shift_held_q <= 1'b0;
      key_q        <= '0;
      ready_q      <= 1'b0;
      clr_q        <= 1'b0;
      rstkey_q     <= 1'b0;
    end else begin
      break_q      <= break_d;
      ext_q        <= ext_d;
      shift_held_q <= shift_held_d;
      key_q        <= key_d;
      ready_q      <= ready_d;
      clr_q        <= clr_d;
      rstkey_q     <= rstkey_d;
    end
  end

  assign bus.dout   = bus.address ? {ready_q, 7'b0} : {1'b1, key_q};
  assign clr_screen = clr_q;
  assign reset_key  = rstkey_q;

endmodule
`default_nettype wire
